scan_decoder: RTL
=================

Name: scan_decoder

Overview:
- Parametrised, registered successor to the combinational 1-to-2 decoder: maps an N-bit row index to a ROWS-wide one-hot output.
- Two modes:
  - Scan mode: the block autonomously sweeps rows with a programmable dwell time.
  - Direct mode: the block decodes an external address.
- Drives row-select lines for the game-of-life LED matrix display. Also usable as a generic registered decoder.

Parameters:
- ROWS, 8, number of one-hot outputs; ROWS >= 2, need not be a power of two.
- N, $clog2(ROWS), width of the address/row index.
- DWELL, 4, cycles each row stays selected in scan mode; DWELL >= 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  enable; when low, out is forced to zero and scan state freezes.
- mode  input  1  0 = scan, 1 = direct.
- addr  input  N  row to select in direct mode; ignored in scan mode.
- out  output  ROWS  registered one-hot row select (all-zero when inactive).
- row  output  N  registered index of the currently selected row.
- wrap  output  1  one-cycle pulse, high in the cycle row first returns to 0 in scan mode.

Behaviour:
- Reset (rst=1 at posedge): row=0, dwell counter cnt=0, active=0, out=0, wrap=0. Reset has priority over all other inputs and aborts any scan mid-dwell.
- All outputs are registered; out always equals (active ? onehot(row) : 0). No combinational path exists from any input to any output.
- Internal state: row[N-1:0], cnt (ceil(log2(DWELL)) bits, min 1), active flag.
- Priority per edge: rst > !ena > first-enable > mode.
- ena=0: active<=0, so out=0 after the edge. wrap<=0. row and cnt hold.
- First enabled edge (ena=1, active=0): active<=1, cnt<=0, wrap<=0, row holds. This gives the first row a full DWELL cycles.
- Direct mode (ena=1, active=1, mode=1):
  - If addr < ROWS: row<=addr, out becomes onehot(addr) one cycle after addr is sampled.
  - If addr >= ROWS (non-power-of-two ROWS): active<=0 for that cycle (out=0), row holds.
  - In both cases cnt<=0 and wrap<=0.
- Scan mode (ena=1, active=1, mode=0):
  - If cnt < DWELL-1: cnt<=cnt+1, row holds, wrap<=0.
  - If cnt == DWELL-1: cnt<=0; row<=(row==ROWS-1) ? 0 : row+1; wrap<=(row==ROWS-1).
- Dwell: every row is selected for exactly DWELL consecutive cycles, including the first row after reset/enable and the row loaded by the last direct-mode edge. Scan resumes from that row.
- DWELL=1: row advances every enabled scan edge; wrap pulses once every ROWS cycles.
- Mode change mid-dwell takes effect at the next edge. Scan→direct discards the partial dwell count.
- ena dropping mid-dwell: cnt is frozen. On re-enable, the first-enable rule reloads cnt=0, so the held row gets a fresh full dwell.
- Wrap-around: ROWS-1 → 0 only. Indices >= ROWS are never produced in scan mode.
- out is one-hot or all-zero on every cycle; never more than one bit set.

Test Plan:
- Reset (ROWS=8, DWELL=4): rst=1 for 2 cycles with ena=1, mode=0 -> out=8'b0, row=0, wrap=0 during and one cycle after release. Then out=8'b0000_0001 for 4 cycles, 8'b0000_0010 for the next 4.
- Full sweep (ROWS=8, DWELL=2): 16 enabled scan cycles after first enable -> out walks bits 0..7, 2 cycles each. wrap=1 exactly in the cycle row returns to 0, and 0 otherwise.
- Direct mode (ROWS=8): mode=1, addr=5 -> out=8'b0010_0000, row=5 one cycle later. Set addr=2 -> next cycle out=8'b0000_0100. Switch mode=0 with DWELL=4 -> row 2 held 4 cycles total from the last direct edge, then row 3.
- Illegal address (ROWS=6, N=3): mode=1, addr=7 -> out=6'b0, row unchanged. addr=5 -> out=6'b10_0000.
- Enable gating (ROWS=8, DWELL=4): drop ena for 3 cycles while on row 3 at cnt=2 -> out=0 during the gap, row stays 3. After re-enable, row 3 shows for a full 4 cycles, then row 4.
- Reset mid-operation and DWELL=1 (ROWS=4, DWELL=1): scan to row 2, assert rst one cycle -> row=0, out=0. After re-enable, out cycles 0001,0010,0100,1000,0001 on consecutive cycles, with wrap high on the second 0001.

Source files
------------

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//   Registered one-hot row decoder with two modes.
//   - Scan mode (mode=0): walks rows 0..ROWS-1, holding each for DWELL cycles.
//   - Direct mode (mode=1): decodes addr; out-of-range addresses blank output.
//   Drives row-select lines of the LED matrix; usable as a generic decoder.
//
// Parameters
//   ROWS  : number of one-hot outputs (>= 2, any value)
//   N     : width of addr / row index
//   DWELL : cycles each row stays selected in scan mode (>= 1)
//
// Ports
//   clk   in            system clock, posedge
//   rst   in            synchronous active-high reset
//   ena   in            enable; low blanks out and freezes scan state
//   mode  in            0 = scan, 1 = direct
//   addr  in  [N-1:0]   row to select in direct mode
//   out   out [ROWS-1:0] registered one-hot row select (zero when inactive)
//   row   out [N-1:0]   registered index of the selected row
//   wrap  out           one-cycle pulse when scan returns to row 0
// ---------------------------------------------------------------------------
module scan_decoder #(
    parameter int ROWS  = 8,
    parameter int N     = $clog2(ROWS),
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            mode,
    input  logic [N-1:0]    addr,
    output logic [ROWS-1:0] out,
    output logic [N-1:0]    row,
    output logic            wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam int            LAST_ROW_I = ROWS - 1;
    localparam logic [N-1:0]  LAST_ROW   = LAST_ROW_I[N-1:0];
    localparam int            LAST_CNT_I = DWELL - 1;
    localparam logic [CW-1:0] LAST_CNT   = LAST_CNT_I[CW-1:0];
    // One extra bit so ROWS itself is representable when ROWS is a power of two.
    localparam logic [N:0]    ROWS_EXT   = ROWS[N:0];

    logic [N-1:0]    row_q,    row_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            active_q, active_d;
    logic            wrap_q,   wrap_d;
    logic [ROWS-1:0] out_q,    out_d;

    always_comb begin
        row_d    = row_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        wrap_d   = 1'b0;

        if (!ena) begin
            active_d = 1'b0;
        end else if (!active_q) begin
            // First enabled edge: show the held row for a full dwell.
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (mode) begin
            cnt_d = '0;
            if ({1'b0, addr} < ROWS_EXT) begin
                row_d = addr;
            end else begin
                active_d = 1'b0;
            end
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (row_q == LAST_ROW) begin
                row_d  = '0;
                wrap_d = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Decode from next-state so out is registered alongside row/active.
        out_d = '0;
        for (int i = 0; i < ROWS; i++) begin
            out_d[i] = active_d && (row_d == i[N-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            wrap_q   <= wrap_d;
            out_q    <= out_d;
        end
    end

    assign out  = out_q;
    assign row  = row_q;
    assign wrap = wrap_q;

endmodule
